// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: run-time phase-shift sequencer for the altpll SDRAM clock output.
// Issues phasestep pulses toward the altpll, waits for the phasedone low/high
// handshake, and tracks the signed net offset. It also holds sys_reset high until
// the PLL has been locked for a settle period.
module pll_phase_ctrl #(
  parameter logic [2:0] CNT_SEL      = 3'd3,
  parameter int         STEP_HOLD    = 2,
  parameter int         DONE_TIMEOUT = 255,
  parameter int         LOCK_SETTLE  = 1024,
  parameter int         OFFSET_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                phasedone,
  output logic                phasestep,
  output logic                phaseupdown,
  output logic [2:0]          phasecounterselect,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OFFSET_W-1:0] req_steps,
  output logic                busy,
  output logic [OFFSET_W-1:0] offset,
  output logic                err,
  output logic                sys_reset
);

  localparam int HOLD_W = $clog2(STEP_HOLD + 1);
  localparam int TO_W   = $clog2(DONE_TIMEOUT + 1);
  localparam int LK_W   = $clog2(LOCK_SETTLE + 1);

  // Largest and most negative representable offsets, one bit wider for headroom maths.
  localparam logic signed [OFFSET_W:0] MAX_X = {2'b00, {(OFFSET_W-1){1'b1}}};
  localparam logic signed [OFFSET_W:0] MIN_X = {2'b11, {(OFFSET_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_IDLE,
    S_STEP,
    S_WAIT_LO,
    S_WAIT_HI
  } state_t;

  state_t              state_q, state_d;
  logic                locked_s1_q, locked_s2_q;
  logic                done_s1_q, done_s2_q;
  logic [LK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [OFFSET_W-1:0] rem_q, rem_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                phasestep_q, phasestep_d;
  logic                phaseupdown_q, phaseupdown_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                sys_reset_q, sys_reset_d;

  // Request decode: saturate the most negative code, then clip to the offset range.
  logic signed [OFFSET_W:0] steps_x, mag_x, head_x, clip_x;
  logic                     req_dir;

  // Two-flop synchronizers for the asynchronous altpll status signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_s1_q <= 1'b0;
      locked_s2_q <= 1'b0;
      done_s1_q   <= 1'b0;
      done_s2_q   <= 1'b0;
    end else begin
      locked_s1_q <= pll_locked;
      locked_s2_q <= locked_s1_q;
      done_s1_q   <= phasedone;
      done_s2_q   <= done_s1_q;
    end
  end

  // Next-state and next-output logic of the step sequencer.
  always_comb begin
    steps_x = {req_steps[OFFSET_W-1], req_steps};
    if (steps_x == MIN_X) steps_x = -MAX_X;
    req_dir = (steps_x > 0);
    mag_x   = (steps_x < 0) ? -steps_x : steps_x;
    head_x  = req_dir ? (MAX_X - {offset_q[OFFSET_W-1], offset_q})
                      : (MAX_X + {offset_q[OFFSET_W-1], offset_q});
    clip_x  = (mag_x < head_x) ? mag_x : head_x;

    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rem_d         = rem_q;
    offset_d      = offset_q;
    phasestep_d   = phasestep_q;
    phaseupdown_d = phaseupdown_q;
    req_ready_d   = req_ready_q;
    busy_d        = busy_q;
    err_d         = err_q;
    sys_reset_d   = sys_reset_q;

    case (state_q)
      S_WAIT_LOCK: begin
        if (!locked_s2_q) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LK_W'(LOCK_SETTLE - 1)) begin
          lock_cnt_d  = '0;
          state_d     = S_IDLE;
          sys_reset_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + LK_W'(1);
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          err_d = 1'b0;
          if (clip_x != 0) begin
            state_d       = S_STEP;
            rem_d         = clip_x[OFFSET_W-1:0];
            phaseupdown_d = req_dir;
            phasestep_d   = 1'b1;
            busy_d        = 1'b1;
            req_ready_d   = 1'b0;
            hold_cnt_d    = '0;
          end
        end
      end
      S_STEP: begin
        if (hold_cnt_q == HOLD_W'(STEP_HOLD - 1)) begin
          state_d     = S_WAIT_LO;
          phasestep_d = 1'b0;
          wait_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!done_s2_q) begin
          state_d    = S_WAIT_HI;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TO_W'(DONE_TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          err_d       = 1'b1;
          rem_d       = '0;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      S_WAIT_HI: begin
        if (done_s2_q) begin
          offset_d = phaseupdown_q ? (offset_q + OFFSET_W'(1)) : (offset_q - OFFSET_W'(1));
          rem_d    = rem_q - OFFSET_W'(1);
          if (rem_q == OFFSET_W'(1)) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            req_ready_d = 1'b1;
          end else begin
            state_d     = S_STEP;
            phasestep_d = 1'b1;
            hold_cnt_d  = '0;
          end
        end else if (wait_cnt_q == TO_W'(DONE_TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          err_d       = 1'b1;
          rem_d       = '0;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase

    // Losing lock outside WAIT_LOCK abandons any sequence; the offset is kept as-is.
    if (state_q != S_WAIT_LOCK && !locked_s2_q) begin
      state_d     = S_WAIT_LOCK;
      phasestep_d = 1'b0;
      sys_reset_d = 1'b1;
      busy_d      = 1'b0;
      req_ready_d = 1'b0;
      lock_cnt_d  = '0;
      rem_d       = '0;
      offset_d    = offset_q;
      if (busy_q) err_d = 1'b1;
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT_LOCK;
      lock_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      rem_q         <= '0;
      offset_q      <= '0;
      phasestep_q   <= 1'b0;
      phaseupdown_q <= 1'b0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      sys_reset_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rem_q         <= rem_d;
      offset_q      <= offset_d;
      phasestep_q   <= phasestep_d;
      phaseupdown_q <= phaseupdown_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      sys_reset_q   <= sys_reset_d;
    end
  end

  assign phasestep          = phasestep_q;
  assign phaseupdown        = phaseupdown_q;
  assign phasecounterselect = CNT_SEL;
  assign req_ready          = req_ready_q;
  assign busy               = busy_q;
  assign offset             = offset_q;
  assign err                = err_q;
  assign sys_reset          = sys_reset_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with a behavioural altpll phasedone model.
module tb_pll_phase_ctrl;

  localparam int STEP_HOLD    = 2;
  localparam int DONE_TIMEOUT = 255;
  localparam int LOCK_SETTLE  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b1;
  logic       phasedone = 1'b1;
  logic       phasestep, phaseupdown;
  logic [2:0] phasecounterselect;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_steps = 8'd0;
  logic       busy;
  logic [7:0] offset;
  logic       err;
  logic       sys_reset;

  int checks = 0;
  int failures = 0;

  // PLL model state and pulse monitor (owned by the negedge process only)
  bit stuck_hi = 1'b0;
  int mcnt = 0;
  bit ps_prev = 1'b0;
  int width = 0;
  int pulse_cnt = 0;
  int up_cnt = 0;
  int down_cnt = 0;
  int bad_width = 0;

  pll_phase_ctrl #(
    .CNT_SEL(3'd3),
    .STEP_HOLD(STEP_HOLD),
    .DONE_TIMEOUT(DONE_TIMEOUT),
    .LOCK_SETTLE(LOCK_SETTLE),
    .OFFSET_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_locked(pll_locked),
    .phasedone(phasedone),
    .phasestep(phasestep),
    .phaseupdown(phaseupdown),
    .phasecounterselect(phasecounterselect),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_steps(req_steps),
    .busy(busy),
    .offset(offset),
    .err(err),
    .sys_reset(sys_reset)
  );

  always #5 clk = ~clk;

  // phasedone drops 3 cycles after a phasestep fall and returns high 4 cycles later;
  // the same process counts phasestep pulses, their direction and their width.
  always @(negedge clk) begin
    if (stuck_hi) begin
      phasedone = 1'b1;
      mcnt = 0;
    end else begin
      if (ps_prev && !phasestep) mcnt = 1;
      else if (mcnt != 0) mcnt = mcnt + 1;
      if (mcnt == 3) phasedone = 1'b0;
      if (mcnt == 7) begin
        phasedone = 1'b1;
        mcnt = 0;
      end
    end
    if (phasestep && !ps_prev) begin
      pulse_cnt = pulse_cnt + 1;
      if (phaseupdown) up_cnt = up_cnt + 1;
      else down_cnt = down_cnt + 1;
      width = 1;
    end else if (phasestep) begin
      width = width + 1;
    end else if (ps_prev && width != STEP_HOLD) begin
      bad_width = bad_width + 1;
    end
    ps_prev = phasestep;
  end

  task automatic send_req(input logic [7:0] s);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_steps = s;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL rst_sys_reset got %b want 1", sys_reset); end
    checks++; if (phasestep !== 1'b0) begin failures++; $display("FAIL rst_phasestep got %b want 0", phasestep); end
    checks++; if (phaseupdown !== 1'b0) begin failures++; $display("FAIL rst_phaseupdown got %b want 0", phaseupdown); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (offset !== 8'd0) begin failures++; $display("FAIL rst_offset got %0d want 0", offset); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (phasecounterselect !== 3'd3) begin failures++; $display("FAIL rst_cntsel got %0d want 3", phasecounterselect); end
  endtask

  // One-cycle lock drop 10 cycles after reset release; sys_reset must fall exactly
  // 18 cycles after lock is restored (2 sync + 16 settle), and not earlier.
  task automatic test_lock_settle();
    int fall_at;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    pll_locked = 1'b0;
    @(posedge clk); #1;
    pll_locked = 1'b1;
    fall_at = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (!sys_reset) begin
        fall_at = i;
        break;
      end
    end
    $display("LOCK settle: sys_reset fell %0d cycles after relock", fall_at);
    checks++; if (fall_at != 18) begin failures++; $display("FAIL lock_settle_cycles got %0d want 18", fall_at); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL lock_settle_ready got %b want 1", req_ready); end
  endtask

  task automatic test_step_up();
    int p0 = pulse_cnt, u0 = up_cnt, bw0 = bad_width;
    bit to;
    send_req(8'sd3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL up_busy_high got %b want 1", busy); end
    wait_ready(200, to);
    $display("REQ steps=+3 offset=%0d pulses=%0d err=%b", $signed(offset), pulse_cnt - p0, err);
    checks++; if (to) begin failures++; $display("FAIL up_timeout got expired want done"); end
    checks++; if (pulse_cnt - p0 != 3) begin failures++; $display("FAIL up_pulses got %0d want 3", pulse_cnt - p0); end
    checks++; if (up_cnt - u0 != 3) begin failures++; $display("FAIL up_dir_pulses got %0d want 3", up_cnt - u0); end
    checks++; if (bad_width != bw0) begin failures++; $display("FAIL up_width got %0d bad want 0", bad_width - bw0); end
    checks++; if (offset !== 8'd3) begin failures++; $display("FAIL up_offset got %0d want 3", $signed(offset)); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL up_busy_low got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL up_err got %b want 0", err); end
    checks++; if (phaseupdown !== 1'b1) begin failures++; $display("FAIL up_updown_hold got %b want 1", phaseupdown); end
  endtask

  task automatic test_step_down();
    int p0 = pulse_cnt, d0 = down_cnt;
    bit to;
    send_req(-8'sd2);
    wait_ready(200, to);
    $display("REQ steps=-2 offset=%0d pulses=%0d err=%b", $signed(offset), pulse_cnt - p0, err);
    checks++; if (to) begin failures++; $display("FAIL down_timeout got expired want done"); end
    checks++; if (pulse_cnt - p0 != 2) begin failures++; $display("FAIL down_pulses got %0d want 2", pulse_cnt - p0); end
    checks++; if (down_cnt - d0 != 2) begin failures++; $display("FAIL down_dir_pulses got %0d want 2", down_cnt - d0); end
    checks++; if (offset !== 8'd1) begin failures++; $display("FAIL down_offset got %0d want 1", $signed(offset)); end
    checks++; if (phaseupdown !== 1'b0) begin failures++; $display("FAIL down_updown got %b want 0", phaseupdown); end
  endtask

  // phasedone stuck high: the step aborts after DONE_TIMEOUT cycles in WAIT_LO.
  task automatic test_timeout();
    int err_at;
    stuck_hi = 1'b1;
    send_req(8'sd1);
    for (int i = 0; i < 10 && phasestep; i++) begin
      @(posedge clk); #1;
    end
    err_at = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (err) begin
        err_at = i;
        break;
      end
    end
    $display("REQ steps=+1 (phasedone stuck) err after %0d cycles offset=%0d", err_at, $signed(offset));
    checks++; if (err_at != DONE_TIMEOUT) begin failures++; $display("FAIL to_cycles got %0d want %0d", err_at, DONE_TIMEOUT); end
    checks++; if (offset !== 8'd1) begin failures++; $display("FAIL to_offset got %0d want 1", $signed(offset)); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL to_ready got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy got %b want 0", busy); end
    stuck_hi = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // A zero request is accepted with no pulse and clears the sticky error.
  task automatic test_zero();
    int p0 = pulse_cnt;
    send_req(8'd0);
    repeat (10) @(posedge clk);
    #1;
    $display("REQ steps=0 offset=%0d pulses=%0d err=%b", $signed(offset), pulse_cnt - p0, err);
    checks++; if (pulse_cnt != p0) begin failures++; $display("FAIL zero_pulses got %0d want 0", pulse_cnt - p0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL zero_err_clear got %b want 0", err); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got %b want 1", req_ready); end
  endtask

  // Lock lost during the 2nd of 4 steps: one step completed, so offset goes 1 -> 2.
  task automatic test_lock_loss();
    int p0 = pulse_cnt;
    bit seen;
    send_req(8'sd4);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pulse_cnt - p0 >= 2) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL ll_second_pulse got none want pulse 2"); end
    pll_locked = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sys_reset) begin
        seen = 1'b1;
        break;
      end
    end
    $display("REQ steps=+4 lock lost: sys_reset=%b err=%b offset=%0d", sys_reset, err, $signed(offset));
    checks++; if (!seen) begin failures++; $display("FAIL ll_sys_reset got 0 want 1"); end
    checks++; if (phasestep !== 1'b0) begin failures++; $display("FAIL ll_phasestep got %b want 0", phasestep); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ll_busy got %b want 0", busy); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL ll_ready got %b want 0", req_ready); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ll_err got %b want 1", err); end
    checks++; if (offset !== 8'd2) begin failures++; $display("FAIL ll_offset got %0d want 2", $signed(offset)); end
    repeat (3) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!sys_reset) begin
        seen = 1'b1;
        break;
      end
    end
    $display("RELOCK sys_reset=%b offset=%0d ready=%b", sys_reset, $signed(offset), req_ready);
    checks++; if (!seen) begin failures++; $display("FAIL ll_relock got sys_reset 1 want 0"); end
    checks++; if (offset !== 8'd2) begin failures++; $display("FAIL ll_relock_offset got %0d want 2", $signed(offset)); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ll_relock_ready got %b want 1", req_ready); end
    checks++; if (pulse_cnt - p0 != 2) begin failures++; $display("FAIL ll_pulses got %0d want 2", pulse_cnt - p0); end
  endtask

  // Offset saturation at +127 and the -128 request treated as -127.
  task automatic test_clip();
    int p0;
    bit to;
    p0 = pulse_cnt;
    send_req(8'sd118);
    wait_ready(3000, to);
    $display("REQ steps=+118 offset=%0d pulses=%0d err=%b", $signed(offset), pulse_cnt - p0, err);
    checks++; if (to || offset !== 8'd120) begin failures++; $display("FAIL clip_pre_offset got %0d want 120", $signed(offset)); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL clip_err_clear got %b want 0", err); end

    p0 = pulse_cnt;
    send_req(8'sd20);
    wait_ready(500, to);
    $display("REQ steps=+20 offset=%0d pulses=%0d", $signed(offset), pulse_cnt - p0);
    checks++; if (to || pulse_cnt - p0 != 7) begin failures++; $display("FAIL clip_pulses got %0d want 7", pulse_cnt - p0); end
    checks++; if (offset !== 8'd127) begin failures++; $display("FAIL clip_offset got %0d want 127", $signed(offset)); end

    p0 = pulse_cnt;
    send_req(8'sd1);
    repeat (10) @(posedge clk);
    #1;
    $display("REQ steps=+1 offset=%0d pulses=%0d", $signed(offset), pulse_cnt - p0);
    checks++; if (pulse_cnt != p0) begin failures++; $display("FAIL clip_sat_pulses got %0d want 0", pulse_cnt - p0); end
    checks++; if (offset !== 8'd127 || req_ready !== 1'b1) begin failures++; $display("FAIL clip_sat_state got offset %0d ready %b want 127 1", $signed(offset), req_ready); end

    p0 = pulse_cnt;
    send_req(8'h80);
    wait_ready(3000, to);
    $display("REQ steps=-128 offset=%0d pulses=%0d", $signed(offset), pulse_cnt - p0);
    checks++; if (to || pulse_cnt - p0 != 127) begin failures++; $display("FAIL neg_min_pulses got %0d want 127", pulse_cnt - p0); end
    checks++; if (offset !== 8'd0) begin failures++; $display("FAIL neg_min_offset got %0d want 0", $signed(offset)); end
  endtask

  initial begin
    test_reset();
    test_lock_settle();
    test_step_up();
    test_step_down();
    test_timeout();
    test_zero();
    test_lock_loss();
    test_clip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
